// File: rtl/node_pkt_pkg.sv
// Shared packet definitions for the node TX assembler and RX decode path.
// Types, lengths, header layout and snapshot bundle.
package node_pkt_pkg;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 5;

  typedef logic [2:0] pkt_type_t;

  localparam pkt_type_t PKT_HB   = 3'b000;
  localparam pkt_type_t PKT_CHE  = 3'b001;
  localparam pkt_type_t PKT_TS   = 3'b100;
  localparam pkt_type_t PKT_DATA = 3'b101;
  localparam pkt_type_t PKT_SOS  = 3'b110;

  localparam logic [LEN_W-1:0] LEN_HB   = 5'd6;
  localparam logic [LEN_W-1:0] LEN_CHE  = 5'd4;
  localparam logic [LEN_W-1:0] LEN_TS   = 5'd4;
  localparam logic [LEN_W-1:0] LEN_DATA = 5'd5;
  localparam logic [LEN_W-1:0] LEN_SOS  = 5'd3;

  localparam int HDR_TYPE_LSB = 13;
  localparam int HDR_LEN_LSB  = 8;

  localparam logic [WORD_W-1:0] HOPS_SAT = 16'hFFFF;

  typedef struct packed {
    logic [WORD_W-1:0] id;
    logic [WORD_W-1:0] hops;
    logic [WORD_W-1:0] emax;
    logic [WORD_W-1:0] emin;
    logic [WORD_W-1:0] eth;
    logic [WORD_W-1:0] ch_id;
    logic [WORD_W-1:0] qval;
    logic [WORD_W-1:0] slot;
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] energy;
  } snap_t;

  function automatic logic [LEN_W-1:0] pkt_len(pkt_type_t t);
    logic [LEN_W-1:0] l;
    unique case (t)
      PKT_HB:   l = LEN_HB;
      PKT_CHE:  l = LEN_CHE;
      PKT_TS:   l = LEN_TS;
      PKT_DATA: l = LEN_DATA;
      PKT_SOS:  l = LEN_SOS;
      default:  l = '0;
    endcase
    return l;
  endfunction

  // Timeslot grants may only come from a cluster head
  function automatic logic pkt_legal(pkt_type_t t, logic role);
    return (pkt_len(t) != '0) && ((t != PKT_TS) || role);
  endfunction

endpackage

// File: rtl/node_pkt_if.sv
// Word stream from the packet assembler to the radio/TX FIFO.
// valid/ready handshake with end-of-packet marker.
interface node_pkt_if;
  import node_pkt_pkg::*;

  logic [WORD_W-1:0] tx_word;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;

  modport master (
    output tx_word,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_word,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/node_pkt_field_mux.sv
// Selects the packet word for a given type and word index.
// Purely combinational; also flags the final word.
module node_pkt_field_mux
  import node_pkt_pkg::*;
(
  input  pkt_type_t         pkt_type,
  input  logic [2:0]        idx,
  input  snap_t             snap,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  logic [LEN_W-1:0]  len;
  logic [WORD_W-1:0] hdr;
  logic [WORD_W-1:0] body;

  assign len  = pkt_len(pkt_type);
  assign hdr  = (WORD_W'(pkt_type) << HDR_TYPE_LSB)
              | (WORD_W'(len) << HDR_LEN_LSB);
  assign last = ({2'b00, idx} == (len - 5'd1));

  always_comb begin
    body = '0;
    unique case (pkt_type)
      PKT_HB: begin
        unique case (idx)
          3'd2:    body = snap.hops;
          3'd3:    body = snap.emax;
          3'd4:    body = snap.emin;
          3'd5:    body = snap.eth;
          default: body = '0;
        endcase
      end
      PKT_CHE: begin
        unique case (idx)
          3'd2:    body = snap.ch_id;
          3'd3:    body = snap.qval;
          default: body = '0;
        endcase
      end
      PKT_TS: begin
        unique case (idx)
          3'd2:    body = snap.ch_id;
          3'd3:    body = snap.slot;
          default: body = '0;
        endcase
      end
      PKT_DATA: begin
        unique case (idx)
          3'd2:    body = snap.ch_id;
          3'd3:    body = snap.hops;
          3'd4:    body = snap.data;
          default: body = '0;
        endcase
      end
      PKT_SOS: begin
        body = (idx == 3'd2) ? snap.energy : '0;
      end
      default: body = '0;
    endcase
  end

  always_comb begin
    word = body;
    unique case (1'b1)
      (idx == 3'd0): word = hdr;
      (idx == 3'd1): word = snap.id;
      default:       word = body;
    endcase
  end

endmodule

// File: rtl/node_pkt_tx.sv
// Node transmit packet assembler: snapshots node state on request
// and streams a typed packet as 16-bit words over valid/ready.
module node_pkt_tx
  import node_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              tx_req,
  input  pkt_type_t         tx_type,
  input  logic [WORD_W-1:0] myNodeID,
  input  logic [WORD_W-1:0] hopsFromSink,
  input  logic [WORD_W-1:0] myQValue,
  input  logic              role,
  input  logic [WORD_W-1:0] energy,
  input  logic [WORD_W-1:0] e_max,
  input  logic [WORD_W-1:0] e_min,
  input  logic [WORD_W-1:0] e_threshold,
  input  logic [WORD_W-1:0] ch_ID,
  input  logic [WORD_W-1:0] timeslot,
  input  logic [WORD_W-1:0] data_word,
  node_pkt_if.master        tx,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_err
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  pkt_type_t         type_q, type_d;
  logic [2:0]        idx_q, idx_d;
  snap_t             snap_q, snap_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              req_idle, accept, hs, fin;
  logic [WORD_W-1:0] hops_inc;
  logic [WORD_W-1:0] mux_word;
  logic              mux_last;

  assign req_idle = (state_q == IDLE) && tx_req;
  assign accept   = req_idle && pkt_legal(tx_type, role);
  assign hs       = (state_q == SEND) && valid_q && tx.tx_ready;
  assign fin      = hs && last_q;
  assign hops_inc = (hopsFromSink == HOPS_SAT) ? HOPS_SAT
                                               : hopsFromSink + 16'd1;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = req_idle && !accept;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = SEND;
          type_d        = tx_type;
          idx_d         = 3'd0;
          busy_d        = 1'b1;
          snap_d.id     = myNodeID;
          snap_d.hops   = (tx_type == PKT_HB) ? hops_inc : hopsFromSink;
          snap_d.emax   = e_max;
          snap_d.emin   = e_min;
          snap_d.eth    = e_threshold;
          snap_d.ch_id  = ch_ID;
          snap_d.qval   = myQValue;
          snap_d.slot   = timeslot;
          snap_d.data   = data_word;
          snap_d.energy = energy;
        end
      end
      SEND: begin
        if (fin) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (hs) begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mux looks at next-state selectors so the outputs can be registered
  node_pkt_field_mux u_mux (
    .pkt_type (type_d),
    .idx      (idx_d),
    .snap     (snap_d),
    .word     (mux_word),
    .last     (mux_last)
  );

  always_comb begin
    word_d  = word_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept || (hs && !fin)) begin
      word_d  = mux_word;
      last_d  = mux_last;
      valid_d = 1'b1;
    end else if (fin) begin
      word_d  = '0;
      last_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      type_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tx.tx_word  = word_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: doc/node_pkt_tx.md
Name: node_pkt_tx

Overview:
- Transmit-side packet assembler for the node: serializes outgoing protocol packets into 16-bit words for the radio/TX FIFO.
- Packet types: heartbeat relay, CH election, timeslot, data, SOS.
- Sits opposite the receive-side node-info/decode path. Takes node state (ID, hops, Q-value, role, energy) plus a send request, snapshots all fields, then streams the packet over a valid/ready handshake.

Parameters:
- WORD_W, 16, packet word width; fixed at 16, exposed for package consistency only.
- LEN_W, 5, width of the length field in the header.

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- tx_req  in  1  single-cycle send request; sampled only in IDLE
- tx_type  in  3  packet type for tx_req
- myNodeID  in  16  source ID
- hopsFromSink  in  16  own hop count
- myQValue  in  16  own Q-value
- role  in  1  1 = cluster head
- energy  in  16  current energy
- e_max  in  16  energy field for HB relay
- e_min  in  16  energy field for HB relay
- e_threshold  in  16  energy field for HB relay
- ch_ID  in  16  destination / elected CH ID
- timeslot  in  16  slot to grant
- data_word  in  16  data payload
- tx_word  out  16  current packet word
- tx_valid  out  1  tx_word valid
- tx_ready  in  1  downstream accepts word
- tx_last  out  1  final word of packet, qualified by tx_valid
- busy  out  1  packet in flight
- tx_done  out  1  one-cycle pulse after last word accepted
- tx_err  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset (nrst=0 at clk edge): state=IDLE; tx_word=0, tx_valid=0, tx_last=0, busy=0, tx_done=0, tx_err=0; word index=0; snapshot regs=0. Reset mid-packet abandons the packet with no tx_done.
- Header word0: [15:13]=type, [12:8]=total word count incl. header, [7:0]=0.
- Word1: myNodeID for all types.
- Type-specific words:
  - 000 HB: word2=hops_inc, then e_max, e_min, e_threshold. Length 6.
  - hops_inc = hopsFromSink+1, saturating at 16'hFFFF.
  - 001 CHE: ch_ID, myQValue. Length 4.
  - 100 timeslot: ch_ID (member dest), timeslot. Length 4. Legal only when role=1.
  - 101 data: ch_ID, hopsFromSink, data_word. Length 5.
  - 110 SOS: energy. Length 3.
- Rejection: types 010, 011, 111, and 100 with role=0 are rejected. tx_err pulses on the cycle after the request; state stays IDLE.
- FSM states: IDLE, SEND.
- IDLE:
  - tx_req=1 with a legal type at edge N → snapshot every field used by that type (hops_inc computed at snapshot), index=0, busy=1, state=SEND.
  - tx_valid=1 with header from cycle N+1.
  - Input changes after N do not affect the packet.
- SEND:
  - tx_valid=1; tx_word=field[index]; tx_last=(index==len-1).
  - tx_valid&tx_ready → index+1.
  - tx_valid&!tx_ready → tx_word, tx_last, index held stable.
  - Handshake on last word → state=IDLE, tx_valid=0, busy=0, tx_done=1 for one cycle.
  - Next request is accepted the cycle after the return to IDLE (no back-to-back in the same cycle).
- tx_req while busy: ignored. No queue, no tx_err.
- tx_ready while tx_valid=0: ignored.
- Outputs are registered; no combinational path from tx_ready to tx_valid.

Decomposition:
- Shared package node_pkt_pkg:
  - packet type constants: PKT_HB=3'b000, PKT_CHE=3'b001, PKT_TS=3'b100, PKT_DATA=3'b101, PKT_SOS=3'b110
  - length constants LEN_HB=6, LEN_CHE=4, LEN_TS=4, LEN_DATA=5, LEN_SOS=3
  - header field positions, HOPS_SAT=16'hFFFF
- Package is shared with the receive/decode path.
- One sub-module: node_pkt_field_mux. Combinational; maps (type, index, snapshot regs) to word and last flag. FSM and snapshot stay in node_pkt_tx.

Test Plan:
- HB: myNodeID=000C, hopsFromSink=3, e_max=0100, e_min=0010, e_threshold=0040, tx_ready=1. Expect words 0600,000C,0004,0100,0010,0040; tx_last on 6th; tx_done next cycle.
- HB hop saturation: hopsFromSink=FFFF → word2=FFFF.
- Backpressure: data pkt, ch_ID=0003, hops=2, data_word=BEEF. tx_ready low 3 cycles at word2. Expect 0003 held stable. Full stream A500,000C,0003,0002,BEEF.
- Rejection: tx_type=100 with role=0 → tx_err pulse, tx_valid stays 0. Same with role=1, timeslot=0007 → 8400,000C,ch_ID,0007. tx_type=011 → tx_err.
- Snapshot/ignore: SOS with energy=0020; energy changed to 0000 and second tx_req issued mid-packet. Expect C300,000C,0020 only, and a single tx_done.
- Reset mid-packet: nrst=0 after word1 → next cycle all outputs 0, no tx_done. A new CHE request afterwards streams correctly from the header.
